// File: rtl/parallel_in_pkg.sv
// Shared constants for the memory-mapped parallel input port.
// Address map and status word bit positions.
package parallel_in_pkg;

  localparam logic [4:0] DATA_ADDR   = 5'h1F;
  localparam logic [4:0] STATUS_ADDR = 5'h1E;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_COUNT_LSB = 3;
  localparam int ST_COUNT_W   = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a pop on empty is ignored and
// a push on full is accepted only when a pop frees a slot on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         popData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign popData = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= pushData;
  end

endmodule

// File: rtl/parallel_in.sv
// Parallel input port: synchronize and debounce the pin bus, queue each new
// stable value, and let the CPU drain the queue through a data/status map.
module parallel_in #(
  parameter int         WIDTH           = 8,
  parameter int         DEPTH           = 4,
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter logic [4:0] DATA_ADDR       = parallel_in_pkg::DATA_ADDR,
  parameter logic [4:0] STATUS_ADDR     = parallel_in_pkg::STATUS_ADDR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pinsIn,
  input  logic             re,
  input  logic [4:0]       address,
  output logic [WIDTH-1:0] readData,
  output logic             irq
);

  import parallel_in_pkg::*;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]        sync_1;
  logic [WIDTH-1:0]        sync_val;
  logic [WIDTH-1:0]        candidate;
  logic [WIDTH-1:0]        committed;
  logic [CW-1:0]           db_cnt;
  logic                    stable;
  logic                    push;
  logic                    pop;
  logic                    overflow;
  logic                    set_ovf;
  logic                    data_rd;
  logic                    status_rd;
  logic [WIDTH-1:0]        head;
  logic [$clog2(DEPTH):0]  count;
  logic                    full;
  logic                    empty;
  logic [WIDTH-1:0]        status_word;

  // Stable fires only on the edge the counter climbs to its limit, so a
  // held value is offered for commit exactly once.
  assign stable    = (sync_val == candidate) && (db_cnt == DB_LAST);
  assign push      = stable && (candidate != committed);
  assign data_rd   = re && (address == DATA_ADDR);
  assign status_rd = re && (address == STATUS_ADDR);
  assign pop       = data_rd && !empty;
  assign set_ovf   = push && full && !pop;
  assign irq       = !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1    <= '0;
      sync_val  <= '0;
      candidate <= '0;
      db_cnt    <= '0;
      committed <= '0;
    end else begin
      sync_1   <= pinsIn;
      sync_val <= sync_1;
      if (sync_val != candidate) begin
        candidate <= sync_val;
        db_cnt    <= '0;
      end else if (db_cnt != DB_MAX) begin
        db_cnt <= db_cnt + 1'b1;
      end
      if (push) committed <= candidate;
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pushData (candidate),
    .pop      (pop),
    .popData  (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    status_word = '0;
    status_word[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(count);
    status_word[ST_OVERFLOW]  = overflow;
    status_word[ST_FULL]      = full;
    status_word[ST_NOT_EMPTY] = !empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      readData <= '0;
    end else begin
      if (set_ovf)        overflow <= 1'b1;
      else if (status_rd) overflow <= 1'b0;

      if (data_rd)        readData <= empty ? '0 : head;
      else if (status_rd) readData <= status_word;
      else if (re)        readData <= '0;
    end
  end

endmodule

// File: tb/tb_parallel_in.sv
// Self-checking bench for parallel_in: directed sequences, a vector table,
// and randomized pins/reads against a queue-based reference model.
module tb_parallel_in;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int DB    = 4;
  localparam logic [4:0] A_DATA = 5'h1F;
  localparam logic [4:0] A_STAT = 5'h1E;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] pinsIn = '0;
  logic             re = 1'b0;
  logic [4:0]       address = '0;
  logic [WIDTH-1:0] readData;
  logic             irq;

  int tests = 0;
  int fails = 0;
  int edge_n = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;

  parallel_in #(
    .WIDTH           (WIDTH),
    .DEPTH           (DEPTH),
    .DEBOUNCE_CYCLES (DB),
    .DATA_ADDR       (A_DATA),
    .STATUS_ADDR     (A_STAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pinsIn   (pinsIn),
    .re       (re),
    .address  (address),
    .readData (readData),
    .irq      (irq)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, exp);
    end
  endtask

  // Reference model: pin history, committed value, a queue for the FIFO.
  int ph[$];
  int mq[$];
  int m_comm;
  int m_ovf;
  int m_rd;

  task automatic model_reset();
    ph.delete();
    for (int i = 0; i < DB + 3; i++) ph.push_back(0);
    mq.delete();
    m_comm = 0;
    m_ovf  = 0;
    m_rd   = 0;
  endtask

  // ph[L-1-k] holds the pin value captured k+1 edges ago; a value is
  // accepted when it was captured DB+1 times in a row right after a change.
  task automatic model_step();
    int L;
    int v;
    bit stable;
    bit push_req;
    bit do_pop;
    bit push_ok;
    bit clr;
    bit setv;
    L = ph.size();
    v = ph[L-2];
    stable = 1'b1;
    for (int j = 0; j <= DB; j++) if (ph[L-2-j] != v) stable = 1'b0;
    if (ph[L-3-DB] == v) stable = 1'b0;
    push_req = stable && (v != m_comm);
    if (push_req) m_comm = v;
    do_pop = 1'b0; clr = 1'b0; setv = 1'b0; push_ok = 1'b0;
    if (re) begin
      if (address == A_DATA) begin
        if (mq.size() > 0) begin
          m_rd = mq[0];
          do_pop = 1'b1;
        end else m_rd = 0;
      end else if (address == A_STAT) begin
        m_rd = (mq.size() * 8) + (m_ovf * 4) + ((mq.size() == DEPTH) ? 2 : 0)
             + ((mq.size() != 0) ? 1 : 0);
        clr = 1'b1;
      end else m_rd = 0;
    end
    if (push_req) begin
      if (mq.size() < DEPTH || do_pop) push_ok = 1'b1;
      else setv = 1'b1;
    end
    if (do_pop)  void'(mq.pop_front());
    if (push_ok) mq.push_back(v);
    if (setv)     m_ovf = 1;
    else if (clr) m_ovf = 0;
    ph.push_back(int'(pinsIn));
    void'(ph.pop_front());
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(negedge clk) begin
    check("model_readData", int'(readData), m_rd);
    check("model_irq", int'(irq), (mq.size() != 0) ? 1 : 0);
  end

  task automatic to_edge(input int n);
    while (edge_n < n) @(negedge clk);
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_read(input logic [4:0] a);
    re = 1'b1;
    address = a;
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic hold_pins(input logic [7:0] v, input int n);
    pinsIn = v;
    wait_edges(n);
  endtask

  typedef struct {
    logic [7:0] pins;
    int         waitn;
    logic       rd_en;
    logic [4:0] addr;
    logic [7:0] exp_rd;
    logic       exp_irq;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int k;
    int hold;
    logic [7:0] pv;
    logic [7:0] pick[5];

    tbl[0] = '{8'h0A, 0,  1'b1, 5'h1F, 8'h00, 1'b0};
    tbl[1] = '{8'h0A, 0,  1'b1, 5'h00, 8'h00, 1'b0};
    tbl[2] = '{8'h5A, 10, 1'b1, 5'h1E, 8'h09, 1'b1};
    tbl[3] = '{8'h5A, 0,  1'b0, 5'h1F, 8'h09, 1'b1};
    tbl[4] = '{8'h5A, 0,  1'b1, 5'h07, 8'h00, 1'b1};
    tbl[5] = '{8'h5A, 0,  1'b1, 5'h1F, 8'h5A, 1'b0};
    tbl[6] = '{8'h5A, 0,  1'b0, 5'h1E, 8'h5A, 1'b0};
    tbl[7] = '{8'h5A, 0,  1'b1, 5'h1F, 8'h00, 1'b0};

    // Reset state
    to_edge(3);
    check("reset_readData", int'(readData), 0);
    check("reset_irq", int'(irq), 0);
    rst_n = 1'b1;

    // Single change: captured at edge 10, pushed at edge 16
    to_edge(9);
    pinsIn = 8'hA5;
    to_edge(15);
    check("single_irq_before_push", int'(irq), 0);
    to_edge(16);
    check("single_irq_after_push", int'(irq), 1);
    do_read(A_DATA);
    check("single_data", int'(readData), 'hA5);
    check("single_irq_drained", int'(irq), 0);

    // Glitch rejection
    hold_pins(8'h00, 10);
    do_read(A_DATA);
    check("return_to_zero", int'(readData), 'h00);
    hold_pins(8'h3C, 2);
    hold_pins(8'h00, 12);
    check("glitch_irq", int'(irq), 0);
    do_read(A_STAT);
    check("glitch_status", int'(readData), 'h00);
    hold_pins(8'h11, 1);
    hold_pins(8'h00, 1);
    hold_pins(8'h11, 12);
    do_read(A_STAT);
    check("bounce_status", int'(readData), 'h09);
    do_read(A_DATA);
    check("bounce_data", int'(readData), 'h11);
    check("bounce_irq", int'(irq), 0);

    // Fill and overflow, then status clear
    for (int v = 1; v <= 5; v++) hold_pins(8'(v), 10);
    do_read(A_STAT);
    check("overflow_status", int'(readData), 'h27);
    do_read(A_STAT);
    check("overflow_cleared", int'(readData), 'h23);
    for (int v = 1; v <= 4; v++) begin
      do_read(A_DATA);
      check("fill_drain", int'(readData), v);
    end
    check("fill_irq_empty", int'(irq), 0);

    // Push onto a full FIFO on the same edge as a pop
    for (int v = 6; v <= 9; v++) hold_pins(8'(v), 10);
    pinsIn = 8'h0A;
    k = edge_n;
    to_edge(k + 6);
    do_read(A_DATA);
    check("simul_pop_data", int'(readData), 'h06);
    do_read(A_STAT);
    check("simul_status", int'(readData), 'h23);
    for (int v = 7; v <= 10; v++) begin
      do_read(A_DATA);
      check("simul_drain", int'(readData), v);
    end

    // Empty, unmapped and idle reads
    for (int i = 0; i < 8; i++) begin
      hold_pins(tbl[i].pins, tbl[i].waitn);
      re = tbl[i].rd_en;
      address = tbl[i].addr;
      @(negedge clk);
      re = 1'b0;
      check($sformatf("vec%0d_readData", i), int'(readData), int'(tbl[i].exp_rd));
      check($sformatf("vec%0d_irq", i), int'(irq), int'(tbl[i].exp_irq));
    end

    // Mid-operation reset with two entries queued and a debounce in flight
    hold_pins(8'h21, 10);
    hold_pins(8'h22, 10);
    do_read(A_STAT);
    check("pre_reset_status", int'(readData), 'h11);
    hold_pins(8'h33, 3);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_readData", int'(readData), 0);
    check("async_reset_irq", int'(irq), 0);
    pinsIn = 8'h80;
    wait_edges(2);
    rst_n = 1'b1;
    k = edge_n;
    to_edge(k + 6);
    check("post_reset_irq_before", int'(irq), 0);
    to_edge(k + 7);
    check("post_reset_irq_after", int'(irq), 1);
    do_read(A_DATA);
    check("post_reset_data", int'(readData), 'h80);

    // Randomized pins and reads against the model
    pick[0] = 8'h00; pick[1] = 8'h01; pick[2] = 8'hFF; pick[3] = 8'hA5; pick[4] = 8'h00;
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        pv = pick[$urandom_range(0, 4)];
        if (pv == 8'h00 && $urandom_range(0, 1) == 1) pv = 8'($urandom);
        pinsIn = pv;
        hold = $urandom_range(1, 12);
      end
      hold--;
      re = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0, 1:    address = A_DATA;
        2:       address = A_STAT;
        default: address = 5'($urandom);
      endcase
      @(negedge clk);
    end
    re = 1'b0;
    wait_edges(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/parallel_in.md
# parallel_in

Memory-mapped parallel input port: the read-side counterpart of the team's parallel output register. Samples an external 8-bit pin bus, synchronizes and debounces it, and queues each new stable value in a small FIFO. The CPU drains the FIFO through a data address and inspects queue state through a status address. `irq` is asserted while data is pending.

## Interface
- `WIDTH`, 8: pin bus and data width.
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles required before a value is accepted; at least 1.
- `DATA_ADDR`, 5'h1F: read address that pops the FIFO.
- `STATUS_ADDR`, 5'h1E: read address for the status word.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `pinsIn`  in  WIDTH: asynchronous external pins.
- `re`  in  1: CPU read strobe.
- `address`  in  5: CPU read address.
- `readData`  out  WIDTH: registered read result.
- `irq`  out  1: FIFO not empty.

## Operation
- **Synchronizer.** Two flops on `pinsIn`; the second-stage output is `syncVal`.
- **Debounce.**
  - Candidate register plus a counter.
  - If `syncVal` differs from the candidate: candidate <= `syncVal`, counter <= 0.
  - Otherwise the counter increments, saturating at `DEBOUNCE_CYCLES`.
  - The candidate is *stable* on the edge where the counter reaches `DEBOUNCE_CYCLES`.
- **Commit.** On the stable edge, if candidate != `committed`: `committed` <= candidate and a push is issued. Equal values push nothing, so a glitch that returns to the old level produces no entry.
- **FIFO.** `DEPTH` entries, read/write pointers of log2(DEPTH) bits, plus a count register of log2(DEPTH)+1 bits.
  - Push while full with no same-cycle pop: the value is dropped and `overflow` is set.
  - Push and pop in the same cycle while full: both succeed and `overflow` is not set.
  - Push and pop in the same cycle while empty: only the push happens. The pop returns 0 and does not pop.
- **Reads** (`re` high, sampled at the edge):
  - `address` == `DATA_ADDR`: `readData` <= FIFO head and the head is popped. If the FIFO is empty, `readData` <= 0 and nothing is popped.
  - `address` == `STATUS_ADDR`: `readData` <= {0…, count[2:0] in bits 5:3, overflow (bit 2), full (bit 1), notEmpty (bit 0)}, using pre-edge values. `overflow` is then cleared, unless a new overflow occurs on the same edge, in which case set wins.
  - Any other address: `readData` <= 0.
  - `re` low: `readData` holds its value.
- `irq` = (count != 0), driven from registered state.

## Timing
- **Reset values** (all outputs and state): `readData` = 0, `irq` = 0. Sync flops, candidate, counter, `committed`, pointers, count and `overflow` are all 0.
- **Reset during a debounce window or with data queued:** everything clears immediately. After release, pins held at a nonzero value produce one push after the normal latency, because `committed` is 0.
- **Pin-to-FIFO latency.** Edge N is the first edge at which sync stage 1 captures the new value. The push occurs at edge N + 2 + `DEBOUNCE_CYCLES`, and `irq` rises after that edge.
- **Read latency:** `readData` is valid after the edge that samples `re`. The pop, count and `irq` update on that same edge.
- **Bounce reset:** any change of `syncVal` inside the window restarts the count.

## Structure
- Package `parallel_in_pkg`:
  - address constants `DATA_ADDR` and `STATUS_ADDR`;
  - status bit-position localparams `ST_NOT_EMPTY`, `ST_FULL`, `ST_OVERFLOW`, `ST_COUNT_LSB`.
- Sub-module `sync_fifo`:
  - parameters `WIDTH` and `DEPTH`;
  - ports `clk`, `rst_n`, `push`, `pushData`, `pop`, `popData`, `count`, `full`, `empty`.
  - The top level contains the synchronizer, debounce, commit, overflow flag and read decode.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.

1. **Single change.** After reset, drive `pinsIn`=8'hA5 before edge 10. Required: push at edge 16, `irq` high after edge 16. Read `DATA_ADDR` → `readData`=8'hA5, then `irq`=0.
2. **Glitch rejection.**
   - Hold 8'h00, pulse 8'h3C for 2 cycles: no push and `irq` stays 0.
   - Bounce 8'h11 for 3 cycles, then hold it: exactly one push of 8'h11.
3. **Fill, overflow and simultaneous push/pop.**
   - Commit 5 distinct values 01..05 without reading. Required: status = count 4, full=1, overflow=1, i.e. 8'h27. DATA reads return 01..04, and the 4th read leaves `irq`=0.
   - Repeat with a pop timed on the same edge as the 5th push: overflow stays 0.
4. **Status clear.** Read status after an overflow → bit 2 set. A second status read → bit 2 clear.
5. **Empty and unmapped reads.**
   - DATA read with the FIFO empty → `readData`=0 and count remains 0.
   - Read at 5'h00 → 0.
   - `re` low → `readData` unchanged.
6. **Mid-operation reset.** Assert `rst_n` low with 2 entries queued and a debounce in progress. Required: `irq`=0 and `readData`=0 immediately. After release with pins at 8'h80, one push of 8'h80 at the normal latency.
